// File: rtl/pc_fetch_pkg.sv
// Shared CPU constants: fetch FSM encodings, reset PC, NOP word and the
// opcode/select values consumed by the next-PC unit.
package pc_fetch_pkg;

  // Fetch FSM state encodings
  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Architectural constants
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0

  // Next-PC unit opcode constants (RV32I major opcodes that redirect the PC)
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  // Next-PC source selection used by the next-PC unit
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JAL    = 2'd2,
    NPC_JALR   = 2'd3
  } npc_sel_e;

  // A fetch target is legal only on a 4-byte boundary
  function automatic logic pc_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC register, issues one instruction
// memory request per instruction, captures the returned word and presents
// it downstream. A misaligned next PC halts the stage until reset.
//
// Handshake semantics (both interfaces): a transfer happens in a cycle where
// valid and ready are both high at the rising edge. Once valid is raised the
// payload (imem_addr / inst, pc) stays stable until the transfer completes.
// imem_rsp_valid has no ready: a response is taken only while in WAIT and is
// dropped in any other state.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        misalign,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  logic [1:0]  state_q,       state_d;
  logic [31:0] pc_q,          pc_d;
  logic [31:0] inst_q,        inst_d;
  logic        misalign_q,    misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Next-state logic: FSM transitions plus PC, instruction and counter updates
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_REQ: begin
        // Responses arriving here are stale (e.g. from before a reset)
        if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rdata;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        // npc is only looked at on the retiring handshake
        if (inst_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          if (pc_aligned(npc)) begin
            pc_d    = npc;
            state_d = ST_REQ;
          end else begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end
        end
      end
      default: begin
        // ST_HALT: everything holds until reset
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      inst_q        <= NOP_INST;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Request is masked during reset so it first rises the cycle after release
  assign imem_req_valid = (state_q == ST_REQ) && !rst;
  assign imem_addr      = pc_q;
  assign inst_valid     = (state_q == ST_VALID);
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign misalign       = misalign_q;
  assign fetch_count    = fetch_count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a scoreboard queue holds the instruction word
// expected for each accepted request; a small model tracks pc/count/misalign.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        misalign;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .npc            (npc),
    .pc             (pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .misalign       (misalign),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
  );

  // Scoreboard and model
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_count;
  logic        exp_mis;
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    check(tag, {30'd0, dbg_state}, {30'd0, exp});
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One full fetch from REQ through the downstream handshake
  task automatic fetch_one(input logic [31:0] data, input int req_stall, input int inst_stall,
                           input logic [31:0] npc_early, input logic [31:0] npc_final);
    logic [31:0] e;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    npc            = npc_early;
    for (int i = 0; i < req_stall; i++) begin
      #1;
      check("req_stall_valid", {31'd0, imem_req_valid}, 32'd1);
      check("req_stall_addr", imem_addr, exp_pc);
      check_state("req_stall_state", ST_REQ);
      tick();
    end
    imem_req_ready = 1'b1;
    #1;
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_addr, exp_pc);
    exp_q.push_back(data);
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata     = data;
    #1;
    check_state("wait_state", ST_WAIT);
    check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rdata     = $urandom;
    #1;
    check("valid_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("valid_req_valid", {31'd0, imem_req_valid}, 32'd0);
    if (exp_q.size() == 0) begin
      e = 32'hxxxx_xxxx;
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("inst_word", inst, e);
    end
    for (int i = 0; i < inst_stall; i++) begin
      if (i == 2) npc = npc_final;
      #1;
      check("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_pc", pc, exp_pc);
      check("stall_inst", inst, e);
      check("stall_count", fetch_count, exp_count);
      tick();
    end
    npc        = npc_final;
    inst_ready = 1'b1;
    #1;
    check("hs_inst_valid", {31'd0, inst_valid}, 32'd1);
    tick();
    inst_ready = 1'b0;
    exp_count  = exp_count + 32'd1;
    if (npc_final[1:0] == 2'b00) begin
      exp_pc = npc_final;
    end else begin
      exp_mis = 1'b1;
    end
    #1;
    check("post_pc", pc, exp_pc);
    check("post_count", fetch_count, exp_count);
    check("post_misalign", {31'd0, misalign}, {31'd0, exp_mis});
    check_state("post_state", exp_mis ? ST_HALT : ST_REQ);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, 32'h0000_0000);
    check({tag, "_inst"}, inst, NOP_INST);
    check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    check({tag, "_count"}, fetch_count, 32'd0);
    check_state({tag, "_state"}, ST_REQ);
  endtask

  // Directed sequence
  initial begin
    rst            = 1'b1;
    npc            = 32'd0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'd0;
    inst_ready     = 1'b0;
    exp_pc         = 32'd0;
    exp_count      = 32'd0;
    exp_mis        = 1'b0;

    // Reset: request must stay low while rst is high
    tick();
    tick();
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_reset_values("reset");

    // Basic fetch with 1-cycle response, npc = pc + 4
    fetch_one(32'h0050_0093, 0, 0, 32'd4, 32'd4);
    // Request stalled 3 cycles
    fetch_one(32'h0010_0113, 3, 0, exp_pc + 32'd4, exp_pc + 32'd4);
    // Downstream stall 5 cycles, npc redirected to 0x40 mid-stall
    fetch_one(32'h0020_8193, 0, 5, exp_pc + 32'd4, 32'h0000_0040);
    // A few randomized fetches
    for (int k = 0; k < 4; k++) begin
      fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                exp_pc + 32'd4, {$urandom_range(0, 255), 2'b00});
    end

    // Counter wrap
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    exp_count = 32'hFFFF_FFFF;
    check("forced_count", fetch_count, 32'hFFFF_FFFF);
    fetch_one(32'h0000_0013, 0, 0, exp_pc + 32'd4, exp_pc + 32'd4);

    // Misaligned npc halts the stage
    fetch_one(32'h0040_0213, 0, 0, 32'h0000_0102, 32'h0000_0102);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hCAFE_F00D;
    inst_ready     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check("halt_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("halt_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("halt_pc", pc, exp_pc);
      check("halt_misalign", {31'd0, misalign}, 32'd1);
      check("halt_count", fetch_count, exp_count);
      check_state("halt_state", ST_HALT);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;

    // Reset out of HALT, then reset in WAIT followed by a stale response
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc    = 32'd0;
    exp_count = 32'd0;
    exp_mis   = 1'b0;
    #1;
    check_reset_values("halt_rst");
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #1;
    check_state("pre_rst_wait", ST_WAIT);
    rst = 1'b1;
    #1;
    check("wait_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    #1;
    check("stale_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check_reset_values("stale_first");
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check_reset_values("stale_after");

    // Normal operation resumes
    fetch_one(32'h0050_0093, 0, 1, 32'd4, 32'd4);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; every flop SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 Port npc, input, 32 bits, SHALL carry the next-PC value from the next-PC unit.
REQ-005 Port pc, output, 32 bits, SHALL carry the current PC register value.
REQ-006 Port imem_req_valid, output, 1 bit, SHALL signal an instruction-memory request.
REQ-007 Port imem_req_ready, input, 1 bit, SHALL signal that the memory accepts a request.
REQ-008 Port imem_addr, output, 32 bits, SHALL carry the request address.
REQ-009 Port imem_rsp_valid, input, 1 bit, SHALL signal that imem_rdata is valid.
REQ-010 Port imem_rdata, input, 32 bits, SHALL carry the instruction word.
REQ-011 Port inst, output, 32 bits, SHALL carry the captured instruction.
REQ-012 Port inst_valid, output, 1 bit, SHALL signal that inst is valid for the pc value.
REQ-013 Port inst_ready, input, 1 bit, SHALL signal that the downstream stage consumes inst; a low level stalls the block.
REQ-014 Port misalign, output, 1 bit, SHALL flag a sticky misaligned-npc halt.
REQ-015 Port fetch_count, output, 32 bits, SHALL count retired fetches.

Function
REQ-016 The block SHALL implement a four-state FSM with states REQ, WAIT, VALID and HALT.
REQ-017 In REQ: imem_req_valid=1 and imem_addr=pc; on imem_req_ready=1 the FSM SHALL go to WAIT.
REQ-018 While in REQ without ready, imem_addr SHALL hold stable.
REQ-019 In REQ, imem_rsp_valid SHALL be ignored, which discards stale responses.
REQ-020 In WAIT: imem_req_valid=0; on imem_rsp_valid=1 the block SHALL capture imem_rdata into inst and go to VALID; minimum request-to-inst_valid latency is 2 cycles.
REQ-021 In VALID: inst_valid=1, and inst and pc SHALL hold stable until the handshake completes.
REQ-022 In VALID with inst_ready=1 and npc[1:0]==0, the block SHALL set pc<=npc, increment fetch_count (wrapping at 2^32-1 to 0), and go to REQ.
REQ-023 In VALID with inst_ready=1 and npc[1:0]!=0, pc SHALL be unchanged, misalign SHALL be set to 1, fetch_count SHALL increment, and the FSM SHALL go to HALT.
REQ-024 In HALT, all outputs SHALL hold, imem_req_valid=0, inst_valid=0, and the FSM SHALL leave HALT only on rst.
REQ-025 inst_valid and imem_req_valid SHALL never be high in the same cycle.
REQ-026 npc SHALL be sampled only at the VALID handshake.

Reset
REQ-027 When rst=1 at a clock edge, from any state or mid-transaction, the block SHALL set pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, misalign=0, fetch_count=0 and state=REQ.
REQ-028 imem_req_valid SHALL be 0 while rst is asserted and SHALL rise in the first cycle after rst deasserts.

Structure
REQ-029 State encodings, RESET_PC and the NOP constant SHALL live in a shared cpu package alongside the next-PC opcode constants.
REQ-030 The FSM SHALL be one flat module with no sub-module; the pc register and fetch counter sit in the same module.

Verification
REQ-031 Reset, then memory with always-high ready and 1-cycle response of 32'h00500093, inst_ready=1, npc=pc+4 -> imem_addr=0 in the first cycle; inst_valid with inst=32'h00500093 two cycles later; pc=4 next.
REQ-032 imem_req_ready low for 3 cycles -> imem_addr stays 0 and imem_req_valid stays 1 throughout; WAIT is entered only on ready.
REQ-033 inst_ready low for 5 cycles in VALID -> pc, inst and inst_valid hold; fetch_count unchanged; with npc changing to 32'h40 on cycle 3 -> pc=32'h40 after the handshake.
REQ-034 npc=32'h0000_0102 at the handshake -> misalign=1, FSM in HALT, pc unchanged; no further requests until rst.
REQ-035 rst asserted in WAIT, then a stale imem_rsp_valid arrives in the first REQ cycle -> response ignored, pc=RESET_PC, inst=32'h0000_0013.
REQ-036 fetch_count preloaded via force to 32'hFFFF_FFFF, then one handshake -> fetch_count=0.
